// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b LSB first over WIDTH cycles, streaming each
// difference bit on t while assembling the parallel result and the final borrow.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             t,
  output logic             t_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StShift = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic            borrow_q, borrow_d;
  logic            t_q, t_d;
  logic            t_valid_q, t_valid_d;
  logic            done_q, done_d;

  logic d_bit;
  logic b_next;

  // Full-subtractor cell on the current LSBs.
  assign d_bit  = sa_q[0] ^ sb_q[0] ^ borrow_q;
  assign b_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & borrow_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    diff_d    = diff_q;
    borrow_d  = borrow_q;
    t_d       = t_q;
    t_valid_d = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          sa_d     = a;
          sb_d     = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          diff_d   = '0;
          state_d  = StShift;
        end
      end
      StShift: begin
        t_d            = d_bit;
        t_valid_d      = 1'b1;
        diff_d[cnt_q]  = d_bit;
        borrow_d       = b_next;
        sa_d           = sa_q >> 1;
        sb_d           = sb_q >> 1;
        if (cnt_q == CntLast) begin
          done_d  = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sa_q      <= '0;
      sb_q      <= '0;
      diff_q    <= '0;
      borrow_q  <= 1'b0;
      t_q       <= 1'b0;
      t_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      diff_q    <= diff_d;
      borrow_q  <= borrow_d;
      t_q       <= t_d;
      t_valid_q <= t_valid_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q == StShift);
  assign t       = t_q;
  assign t_valid = t_valid_q;
  assign done    = done_q;
  assign diff    = diff_q;
  assign borrow  = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4) with hand-computed differences.
module tb_serial_subtractor;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       t;
  logic       t_valid;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       borrow;

  int total;
  int bad;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .t      (t),
    .t_valid(t_valid),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Edge that sees start=1 is E0; returns at the negedge after it.
  task automatic accept();
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("accept t_valid", 32'(t_valid), 32'd0);
    check("accept done", 32'(done), 32'd0);
    check("accept busy", 32'(busy), 32'd1);
  endtask

  task automatic launch(input logic [3:0] av, input logic [3:0] bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    accept();
  endtask

  // Follows edges E1..E4; returns at the negedge of the done cycle.
  task automatic stream(input logic [3:0] exp_diff, input logic exp_borrow, input bit inject);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("t_valid[%0d]", i), 32'(t_valid), 32'd1);
      check($sformatf("t[%0d]", i), 32'(t), 32'(exp_diff[i]));
      check($sformatf("busy[%0d]", i), 32'(busy), (i < 3) ? 32'd1 : 32'd0);
      check($sformatf("done[%0d]", i), 32'(done), (i == 3) ? 32'd1 : 32'd0);
      if (i == 3) begin
        check("diff", 32'(diff), 32'(exp_diff));
        check("borrow", 32'(borrow), 32'(exp_borrow));
      end
      if (inject && i == 0) begin
        start = 1'b1;
        a     = 4'hf;
        b     = 4'h0;
      end
      if (inject && i == 1) start = 1'b0;
    end
  endtask

  task automatic idle_check(input logic last_t);
    @(posedge clk);
    @(negedge clk);
    check("idle t_valid", 32'(t_valid), 32'd0);
    check("idle done", 32'(done), 32'd0);
    check("idle busy", 32'(busy), 32'd0);
    check("idle t hold", 32'(t), 32'(last_t));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    start = 1'b0;
    a     = 4'h0;
    b     = 4'h0;

    repeat (2) @(negedge clk);
    check("rst t", 32'(t), 32'd0);
    check("rst t_valid", 32'(t_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst diff", 32'(diff), 32'd0);
    check("rst borrow", 32'(borrow), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post-rst busy", 32'(busy), 32'd0);

    // 5 - 3 = 2
    launch(4'b0101, 4'b0011);
    stream(4'b0010, 1'b0, 1'b0);
    idle_check(1'b0);

    // 3 - 5 = -2
    launch(4'b0011, 4'b0101);
    stream(4'b1110, 1'b1, 1'b0);
    idle_check(1'b1);

    // 0 - 1 = -1
    launch(4'b0000, 4'b0001);
    stream(4'b1111, 1'b1, 1'b0);
    idle_check(1'b1);

    // 0 - 0: zero run
    launch(4'b0000, 4'b0000);
    stream(4'b0000, 1'b0, 1'b0);
    idle_check(1'b0);

    // 9 - 4 = 5 with a start pulse at E2 carrying other operands
    launch(4'b1001, 4'b0100);
    stream(4'b0101, 1'b0, 1'b1);
    idle_check(1'b0);

    // Back-to-back: 12 - 10 = 2, then 6 - 9 = -3
    launch(4'b1100, 4'b1010);
    stream(4'b0010, 1'b0, 1'b0);
    start = 1'b1;
    a     = 4'b0110;
    b     = 4'b1001;
    accept();
    stream(4'b1101, 1'b1, 1'b0);
    idle_check(1'b1);

    // Reset between E2 and E3 of 5 - 3
    launch(4'b0101, 4'b0011);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid-rst t_valid", 32'(t_valid), 32'd0);
    check("mid-rst busy", 32'(busy), 32'd0);
    check("mid-rst diff", 32'(diff), 32'd0);
    check("mid-rst borrow", 32'(borrow), 32'd0);
    check("mid-rst done", 32'(done), 32'd0);
    check("mid-rst t", 32'(t), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("held-rst done[%0d]", k), 32'(done), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("rel busy", 32'(busy), 32'd0);

    // Fresh 10 - 3 = 7 after reset
    launch(4'b1010, 4'b0011);
    stream(4'b0111, 1'b0, 1'b0);
    idle_check(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor that computes A − B over WIDTH clock cycles, LSB first.
- Emits each difference bit on serial output t, with a t_valid qualifier, for the downstream pattern-detecting Moore machine that samples t.
- Also returns the assembled parallel difference and the final borrow.
- Uses a start/busy/done handshake with the controller.

Parameters:
- WIDTH, 4, operand, difference and bit-stream length in bits (legal range 2 to 16).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-low: when 0, all state clears immediately, independent of clk.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- t  output  1  current serial difference bit, registered.
- t_valid  output  1  t holds a valid difference bit this cycle.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse with the final bit.
- diff  output  WIDTH  parallel difference, built up LSB first.
- borrow  output  1  running borrow; final value valid when done=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, bit counter=0, operand shift registers=0, borrow=0.
  - t=0, t_valid=0, done=0, diff=0, busy=0.
  - Release is synchronous to the next clk edge; no operation starts on that edge unless start=1.
- States: IDLE and SHIFT. busy = (state==SHIFT), decoded combinationally from the state register.
- IDLE:
  - On an edge with start=1: load sa<=a, sb<=b, borrow<=0, cnt<=0, diff<=0, state<=SHIFT. Call this edge E0.
  - t_valid<=0 and done<=0 on this edge.
  - start=0 keeps IDLE and clears t_valid/done.
- SHIFT, at each edge E1..EWIDTH, using bit i = cnt:
  - d = sa[0] ^ sb[0] ^ borrow.
  - bnext = (~sa[0] & sb[0]) | (~(sa[0]^sb[0]) & borrow).
  - Registered updates: t<=d, t_valid<=1, diff[i]<=d, borrow<=bnext, sa/sb shift right by 1 (zero fill), cnt<=cnt+1.
  - At EWIDTH (cnt==WIDTH-1): done<=1, state<=IDLE, cnt<=0.
- Latency:
  - Bit i appears on t in the cycle after edge E(i+1).
  - The first bit is visible one cycle after acceptance.
  - done, the last t bit, the final diff and the final borrow are all valid together, in the cycle after EWIDTH.
  - That is WIDTH+1 cycles after E0.
- Arithmetic:
  - diff = (a − b) mod 2^WIDTH.
  - borrow=1 if and only if a < b (unsigned).
- Back-to-back: during the done cycle the state is already IDLE, so start=1 on edge EWIDTH+1 is accepted. That edge reloads and clears t_valid/done; the next bit stream starts one cycle later.
- start while busy: ignored; a and b are not re-sampled and no restart occurs.
- t holds its last value when t_valid=0. The downstream block must qualify t with t_valid.
- Reset mid-SHIFT:
  - Outputs clear immediately, asynchronously.
  - The partial result is discarded; no done pulse is produced.
- Operands changing during SHIFT have no effect; only the E0 capture is used.

Test Plan:
- Reset, then start with a=0101, b=0011, WIDTH=4:
  - t_valid high for 4 cycles, t sequence 0,1,0,0.
  - done with diff=0010, borrow=0, on cycle E0+5.
  - busy high for exactly 4 cycles.
- a=0011, b=0101:
  - t sequence 0,1,1,1.
  - diff=1110, borrow=1 at done.
- a=0000, b=0001:
  - t sequence 1,1,1,1, diff=1111, borrow=1.
- a=0000, b=0000:
  - four t=0 bits with t_valid=1, diff=0000, borrow=0.
  - This is the zero-run stimulus for the downstream detector.
- start pulsed at E2 while busy, with different a/b:
  - ignored; the original result completes.
- Back-to-back: start held high on the done cycle:
  - second operation accepted, t_valid low for exactly one cycle between streams.
- Reset=0 asserted mid-stream (between edges E2 and E3):
  - t_valid, busy, diff and borrow drop to 0 immediately, no done pulse.
  - After release, the next start yields a correct fresh result.
